data_plane_rx: RTL
==================

# data_plane_rx

Receive half of the communications-processor data plane. Accepts 32-bit data-plane packets from the interconnect, filters them on the local node ID, reassembles framed payloads and buffers the 16-bit payload words in a small FIFO. The GPP drains the buffer through a valid/ack handshake. The block sits between the network ingress port and the GPP, mirroring `data_plane_tx`.

## Interface

Parameters:
- `FIFO_DEPTH`, 8: payload FIFO depth in words; power of two, 2..64.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `node_id`  in  16  local node ID; quasi-static.
- `data_rx_flag_in`  in  1  packet valid from network.
- `data_rx_packet`  in  32  packet: [31:16] destination ID, [15:0] payload.
- `rx_ready`  out  1  block can accept a packet this cycle.
- `gpp_rx_signal`  out  1  word available to GPP (FIFO non-empty).
- `gpp_rx_data`  out  16  head-of-FIFO payload word.
- `gpp_rx_last`  out  1  head word is last of its frame.
- `gpp_rx_ack`  in  1  GPP consumes head word.
- `rx_busy`  out  1  frame in progress (state != IDLE).
- `rx_err_count`  out  8  aborted-frame counter, saturating at 255.

## Operation

- Accept = `data_rx_flag_in & rx_ready`; a packet not accepted must be held by the network. No packet is ever silently dropped on backpressure.
- `rx_ready` = FIFO not full, independent of state.
- Match = `data_rx_packet[31:16] == node_id`, or `== 16'hFFFF` when broadcast is enabled.
- Frame = one header packet (payload = word count N) followed by N payload packets.
- FSM states:
  - IDLE:
    - Accepted matching header with N != 0: latch N into the remaining counter, go to PAYLOAD.
    - N == 0: ignored, stay IDLE.
    - Non-matching packet: ignored, no error.
  - PAYLOAD:
    - Accepted matching packet: push {last, payload}, where last = (remaining == 1). Decrement the counter; on last go to IDLE.
    - Accepted non-matching packet: frame abort. `rx_err_count`++ (saturating), go to IDLE, packet discarded.
    - Words already pushed remain in the FIFO; none of them carries `last`.
- GPP side, show-ahead FIFO:
  - `gpp_rx_data` and `gpp_rx_last` are valid whenever `gpp_rx_signal` = 1.
  - Pop = `gpp_rx_ack & gpp_rx_signal`; ack while empty is ignored.
- Simultaneous push and pop:
  - Allowed at any occupancy below full; occupancy is unchanged.
  - At full, no push is possible (`rx_ready` = 0); a pop raises `rx_ready` the next cycle.
- Pointers are log2(FIFO_DEPTH) bits plus one wrap bit. Full/empty are derived from pointer equality and the wrap bit.

## Timing

- Reset values:
  - `rx_ready` = 1, `gpp_rx_signal` = 0, `gpp_rx_data` = 0, `gpp_rx_last` = 0, `rx_busy` = 0, `rx_err_count` = 0.
  - State = IDLE; FIFO empty.
- Reset mid-frame: immediate return to IDLE, FIFO flushed, counters cleared.
- Latency: a payload packet accepted at edge k gives `gpp_rx_signal` = 1 after edge k, i.e. visible in cycle k+1.
- Throughput: one packet per cycle in; one word per cycle out.
- `rx_ready` is registered from FIFO occupancy:
  - It falls in the cycle after the FIFO fills.
  - It rises in the cycle after a pop from full.
- `rx_busy` rises after the header edge and falls after the last-payload edge or the abort edge.

## Configuration

- `DATA_PLANE_RX_BCAST_EN` defined: destination 16'hFFFF matches every node, for headers and payloads.
- Not defined: 16'hFFFF is treated as an ordinary ID; it matches only if `node_id` == 16'hFFFF.

## Structure

- Shared package `data_plane_pkg`:
  - Packet field typedef (dest/payload struct).
  - `BCAST_ID` = 16'hFFFF.
  - FSM state enum (IDLE, PAYLOAD).
  - FIFO entry typedef {last, data}.
- One sub-module: `data_plane_rx_fifo`, a parameterised show-ahead synchronous FIFO with push/pop/full/empty. The FSM, counter and match logic stay in `data_plane_rx`.

## Test plan

- **Reset:** hold `rst` = 0 mid-frame, release. Required: all outputs at reset values, `rx_ready` = 1, FIFO empty.
- **Basic frame:** `node_id` = 16'h0001; header 32'h0001_0003, then payloads 0x000A, 0x0005, 0x0002 back to back, `gpp_rx_ack` = 1. Required: GPP sees 000A, 0005, 0002 on consecutive cycles, `gpp_rx_last` only on 0002, `rx_busy` low after the last edge.
- **Address filter:** header 32'h0002_0002 plus two payloads at `node_id` 0x0001. Required: no `gpp_rx_signal`, `rx_err_count` = 0, `rx_busy` stays 0.
- **Backpressure:** FIFO_DEPTH = 8, `gpp_rx_ack` = 0, frame N = 10. Required: `rx_ready` drops after 8 words are pushed and the network holds word 9. After acks, all 10 words arrive in order with `last` on word 10.
- **Abort:** header N = 4, two matching payloads, then packet dest 0x0003. Required: `rx_err_count` = 1, state IDLE, 2 words delivered with no `last`, and a following valid frame is received correctly.
- **Broadcast:** header 32'hFFFF_0001 + payload 0x00BE. Required: word delivered with the macro defined; ignored without it.

Source files
------------

// File: rtl/data_plane_pkg.sv
// rtl/data_plane_pkg.sv - shared data-plane packet, FSM state and FIFO entry types
package data_plane_pkg;

    localparam logic [15:0] BCAST_ID = 16'hFFFF;

    typedef struct packed {
        logic [15:0] dest;
        logic [15:0] payload;
    } dp_packet_t;

    typedef enum logic {
        IDLE,
        PAYLOAD
    } rx_state_t;

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } rx_entry_t;

endpackage

// File: rtl/data_plane_rx_fifo.sv
// rtl/data_plane_rx_fifo.sv - show-ahead synchronous FIFO of payload entries
module data_plane_rx_fifo
    import data_plane_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  rx_entry_t wr_entry,
    input  logic      pop,
    output rx_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    rx_entry_t   mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // The extra MSB distinguishes full from empty when the index bits coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

endmodule

// File: rtl/data_plane_rx.sv
// rtl/data_plane_rx.sv - data-plane receive: node filter, frame reassembly, GPP buffer
// Optional broadcast match on 16'hFFFF enabled by DATA_PLANE_RX_BCAST_EN.
module data_plane_rx
    import data_plane_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] node_id,
    input  logic        data_rx_flag_in,
    input  logic [31:0] data_rx_packet,
    output logic        rx_ready,
    output logic        gpp_rx_signal,
    output logic [15:0] gpp_rx_data,
    output logic        gpp_rx_last,
    input  logic        gpp_rx_ack,
    output logic        rx_busy,
    output logic [7:0]  rx_err_count
);

    dp_packet_t pkt;
    rx_state_t  state, state_next;
    logic [15:0] remaining, remaining_next;
    logic [7:0]  err_next;
    logic        match;
    logic        accept;
    logic        push;
    rx_entry_t   wr_entry;
    rx_entry_t   head;
    logic        full;
    logic        empty;

    assign pkt = data_rx_packet;

`ifdef DATA_PLANE_RX_BCAST_EN
    assign match = (pkt.dest == node_id) || (pkt.dest == BCAST_ID);
`else
    assign match = (pkt.dest == node_id);
`endif

    assign rx_ready      = ~full;
    assign accept        = data_rx_flag_in & rx_ready;
    assign gpp_rx_signal = ~empty;
    assign gpp_rx_data   = head.data;
    assign gpp_rx_last   = head.last;
    assign rx_busy       = (state == PAYLOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            remaining    <= '0;
            rx_err_count <= '0;
        end else begin
            state        <= state_next;
            remaining    <= remaining_next;
            rx_err_count <= err_next;
        end
    end

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        err_next       = rx_err_count;
        push           = 1'b0;
        wr_entry       = '{last: (remaining == 16'd1), data: pkt.payload};
        case (state)
            IDLE: begin
                if (accept && match && (pkt.payload != 16'd0)) begin
                    remaining_next = pkt.payload;
                    state_next     = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (match) begin
                        push           = 1'b1;
                        remaining_next = remaining - 16'd1;
                        if (remaining == 16'd1) state_next = IDLE;
                    end else begin
                        // Foreign packet mid-frame aborts; already-buffered words stay.
                        if (rx_err_count != 8'hFF) err_next = rx_err_count + 8'd1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    data_plane_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (gpp_rx_ack),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

endmodule
